// File: rtl/fault_log_pkg.sv
// Shared definitions for the fault event logger: source bit positions,
// counter-select codes, entry layout and the default FIFO depth.
package fault_log_pkg;

    localparam int SRC_W         = 5;
    localparam int TS_W          = 27;
    localparam int ENTRY_W       = SRC_W + TS_W;
    localparam int DEPTH_DEFAULT = 8;

    // Bit position of each fault source inside the src field.
    localparam int SRC_S_IMEM   = 0;
    localparam int SRC_D_IMEM   = 1;
    localparam int SRC_S_DMEM   = 2;
    localparam int SRC_D_DMEM   = 3;
    localparam int SRC_HW_FAULT = 4;

    // Codes accepted on cnt_sel.
    typedef enum logic [2:0] {
        SEL_S_IMEM   = 3'd0,
        SEL_D_IMEM   = 3'd1,
        SEL_S_DMEM   = 3'd2,
        SEL_D_DMEM   = 3'd3,
        SEL_HW_FAULT = 3'd4,
        SEL_DROP     = 3'd5,
        SEL_TOTAL    = 3'd6,
        SEL_NONE     = 3'd7
    } cnt_sel_e;

    // One logged event: which sources rose, and when.
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [TS_W-1:0]  ts;
    } fault_entry_t;

    function automatic fault_entry_t make_entry(input logic [SRC_W-1:0] src,
                                                input logic [TS_W-1:0]  ts);
        fault_entry_t e;
        e.src = src;
        e.ts  = ts;
        return e;
    endfunction

endpackage

// File: rtl/fault_evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding fault entries.
// Pointers carry one extra MSB so full and empty can be told apart.
module fault_evt_fifo
    import fault_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only visible through pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fault_event_logger.sv
// Fault event logger: detects rising edges on ECC and ALU fault flags,
// timestamps them into a FWFT FIFO and keeps saturating statistics.
module fault_event_logger
    import fault_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_err_imem,
    input  logic               d_err_imem,
    input  logic               s_err_dmem,
    input  logic               d_err_dmem,
    input  logic               hardware_fault_flag,
    input  logic               clr,
    input  logic               ev_ready,
    output logic               ev_valid,
    output logic [ENTRY_W-1:0] ev_data,
    output logic               overflow,
    input  logic [2:0]         cnt_sel,
    output logic [CNT_W-1:0]   cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SRC_W-1:0]   flags;
    logic [SRC_W-1:0]   flag_q;
    logic [SRC_W-1:0]   rise;
    logic [TS_W-1:0]    ts;
    logic               evt;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] entry;
    logic [CNT_W-1:0]   src_cnt [SRC_W];
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   total_cnt;

    // Gather the fault inputs into the src bit order used by entries.
    always_comb begin
        flags               = '0;
        flags[SRC_S_IMEM]   = s_err_imem;
        flags[SRC_D_IMEM]   = d_err_imem;
        flags[SRC_S_DMEM]   = s_err_dmem;
        flags[SRC_D_DMEM]   = d_err_dmem;
        flags[SRC_HW_FAULT] = hardware_fault_flag;
    end

    assign rise     = flags & ~flag_q;
    assign evt      = |rise;
    assign ev_valid = ~fifo_empty;
    assign pop      = ev_valid & ev_ready;
    assign drop     = evt & fifo_full & ~pop;
    assign entry    = make_entry(rise, ts);

    // Flag history for edge detection; cleared so a flag held across reset rises after it.
    always_ff @(posedge clk) begin
        if (rst) flag_q <= '0;
        else     flag_q <= flags;
    end

    // Free-running timestamp, wraps naturally at 27 bits; clr does not touch it.
    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + 1'b1;
    end

    fault_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt),
        .push_data (entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (ev_data)
    );

    // Sticky drop indicator; clr wins over a drop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) overflow <= 1'b0;
        else if (drop)  overflow <= 1'b1;
    end

    // Saturating statistics; clr wins over any coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < SRC_W; i++) src_cnt[i] <= '0;
            drop_cnt  <= '0;
            total_cnt <= '0;
        end else begin
            for (int i = 0; i < SRC_W; i++) begin
                if (rise[i] && (src_cnt[i] != CNT_MAX)) src_cnt[i] <= src_cnt[i] + 1'b1;
            end
            if (evt && (total_cnt != CNT_MAX)) total_cnt <= total_cnt + 1'b1;
            if (drop && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Registered counter readback, one cycle behind cnt_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_out <= '0;
        end else begin
            case (cnt_sel_e'(cnt_sel))
                SEL_S_IMEM:   cnt_out <= src_cnt[SRC_S_IMEM];
                SEL_D_IMEM:   cnt_out <= src_cnt[SRC_D_IMEM];
                SEL_S_DMEM:   cnt_out <= src_cnt[SRC_S_DMEM];
                SEL_D_DMEM:   cnt_out <= src_cnt[SRC_D_DMEM];
                SEL_HW_FAULT: cnt_out <= src_cnt[SRC_HW_FAULT];
                SEL_DROP:     cnt_out <= drop_cnt;
                SEL_TOTAL:    cnt_out <= total_cnt;
                default:      cnt_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fault_event_logger.sv
// Bench for fault_event_logger: queue-based reference model plus directed scenarios.
module tb_fault_event_logger;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_err_imem = 1'b0;
    logic             d_err_imem = 1'b0;
    logic             s_err_dmem = 1'b0;
    logic             d_err_dmem = 1'b0;
    logic             hardware_fault_flag = 1'b0;
    logic             clr = 1'b0;
    logic             ev_ready = 1'b0;
    logic             ev_valid;
    logic [31:0]      ev_data;
    logic             overflow;
    logic [2:0]       cnt_sel = 3'd0;
    logic [CNT_W-1:0] cnt_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq[$];
    int          m_ts = 0;
    logic [4:0]  m_prev = '0;
    int          m_cnt[7];
    logic        m_ovf = 1'b0;
    int          m_cnt_out = 0;
    bit          m_live = 1'b0;

    fault_event_logger #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_err_imem          (s_err_imem),
        .d_err_imem          (d_err_imem),
        .s_err_dmem          (s_err_dmem),
        .d_err_dmem          (d_err_dmem),
        .hardware_fault_flag (hardware_fault_flag),
        .clr                 (clr),
        .ev_ready            (ev_ready),
        .ev_valid            (ev_valid),
        .ev_data             (ev_data),
        .overflow            (overflow),
        .cnt_sel             (cnt_sel),
        .cnt_out             (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour for one clock edge: counters indexed 0-4 sources, 5 drops, 6 events.
    task automatic modelStep();
        logic [4:0] fl;
        logic [4:0] rs;
        bit         dropped;
        dropped = 1'b0;
        fl = {hardware_fault_flag, d_err_dmem, s_err_dmem, d_err_imem, s_err_imem};
        if (rst) begin
            mq.delete();
            m_ts = 0;
            m_prev = '0;
            for (int i = 0; i < 7; i++) m_cnt[i] = 0;
            m_ovf = 1'b0;
            m_cnt_out = 0;
            m_live = 1'b1;
        end else begin
            m_cnt_out = (cnt_sel == 3'd7) ? 0 : m_cnt[cnt_sel];
            rs = fl & ~m_prev;
            m_prev = fl;
            if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
            if (rs != 0) begin
                if (mq.size() < DEPTH) mq.push_back({rs, m_ts[26:0]});
                else dropped = 1'b1;
            end
            if (clr) begin
                for (int i = 0; i < 7; i++) m_cnt[i] = 0;
                m_ovf = 1'b0;
            end else begin
                for (int i = 0; i < 5; i++)
                    if (rs[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
                if (rs != 0 && m_cnt[6] < CNT_MAX) m_cnt[6]++;
                if (dropped) begin
                    if (m_cnt[5] < CNT_MAX) m_cnt[5]++;
                    m_ovf = 1'b1;
                end
            end
            m_ts = (m_ts + 1) % (1 << 27);
        end
    endtask

    task automatic compareAll();
        checkOutput("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) checkOutput("ev_data", ev_data, mq[0]);
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("cnt_out", 32'(cnt_out), 32'(m_cnt_out));
    endtask

    // Model advances on every rising edge.
    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Outputs are compared against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (m_live) compareAll();
    end

    // Drive flags/ready/clr for one cycle; flg bit order matches the src field.
    task automatic applyStimulus(input logic [4:0] flg, input logic rdy, input logic c);
        {hardware_fault_flag, d_err_dmem, s_err_dmem, d_err_imem, s_err_imem} = flg;
        ev_ready = rdy;
        clr = c;
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        {hardware_fault_flag, d_err_dmem, s_err_dmem, d_err_imem, s_err_imem} = '0;
        ev_ready = 1'b0;
        clr = 1'b0;
        cnt_sel = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitTs(input int target);
        for (int n = 0; n < 1000 && m_ts != target; n++) @(negedge clk);
        checkOutput("wait_timestamp", 32'(m_ts), 32'(target));
    endtask

    task automatic selCheck(input string name, input logic [2:0] sel, input int expected);
        cnt_sel = sel;
        @(negedge clk);
        checkOutput(name, 32'(cnt_out), 32'(expected));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        logic [31:0] last;

        // Reset state
        applyReset();
        checkOutput("rst_ev_valid", 32'(ev_valid), 32'd0);
        checkOutput("rst_ev_data", ev_data, 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_cnt_out", 32'(cnt_out), 32'd0);

        // Single hardware fault pulse at timestamp 100
        waitTs(100);
        applyStimulus(5'b10000, 1'b1, 1'b0);
        checkOutput("hw_valid", 32'(ev_valid), 32'd1);
        checkOutput("hw_entry", ev_data, 32'h8000_0064);
        cnt_sel = 3'd4;
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("hw_drained", 32'(ev_valid), 32'd0);
        checkOutput("hw_cnt4", 32'(cnt_out), 32'd1);

        // Simultaneous rises merge into one entry
        applyReset();
        waitTs(5);
        applyStimulus(5'b10100, 1'b0, 1'b0);
        checkOutput("merge_entry", ev_data, 32'hA000_0005);
        applyStimulus(5'b00000, 1'b0, 1'b0);
        selCheck("merge_total", 3'd6, 1);
        selCheck("merge_cnt2", 3'd2, 1);
        selCheck("merge_cnt4", 3'd4, 1);
        selCheck("merge_cnt0", 3'd0, 0);
        selCheck("merge_sel7", 3'd7, 0);

        // Ten pulses with consumer stalled: two drops, then in-order drain
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'b00001, 1'b0, 1'b0);
            applyStimulus(5'b00000, 1'b0, 1'b0);
        end
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        selCheck("ovf_drop_cnt", 3'd5, 2);
        selCheck("ovf_total", 3'd6, 10);
        selCheck("ovf_cnt0", 3'd0, 10);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_valid", 32'(ev_valid), 32'd1);
            checkOutput("drain_entry", ev_data, 32'h0800_0000 + 32'(2 * i));
            ev_ready = 1'b1;
            @(negedge clk);
        end
        checkOutput("drain_empty", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // Full FIFO with pop and new rise in the same cycle
        applyReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(5'b00001, 1'b0, 1'b0);
            applyStimulus(5'b00000, 1'b0, 1'b0);
        end
        applyStimulus(5'b00010, 1'b1, 1'b0);
        d_err_imem = 1'b0;
        checkOutput("full_pp_ovf", 32'(overflow), 32'd0);
        n = 0;
        last = '0;
        for (int k = 0; k < 20; k++) begin
            if (ev_valid) begin
                n++;
                last = ev_data;
            end
            @(negedge clk);
        end
        checkOutput("full_pp_occupancy", 32'(n), 32'd8);
        checkOutput("full_pp_last", last, 32'h1000_0010);
        selCheck("full_pp_drop", 3'd5, 0);

        // Held flag counts once; clr beats a coincident rise but the entry still queues
        applyReset();
        applyStimulus(5'b01000, 1'b1, 1'b0);
        repeat (49) @(negedge clk);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        selCheck("held_cnt3", 3'd3, 1);
        applyStimulus(5'b00001, 1'b0, 1'b1);
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("clr_entry_valid", 32'(ev_valid), 32'd1);
        selCheck("clr_cnt0", 3'd0, 0);
        selCheck("clr_total", 3'd6, 0);
        selCheck("clr_cnt3", 3'd3, 0);

        // Reset with entries queued, flag held high across reset
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b00100, 1'b0, 1'b0);
            applyStimulus(5'b00000, 1'b0, 1'b0);
        end
        selCheck("pre_rst_total", 3'd6, 3);
        rst = 1'b1;
        hardware_fault_flag = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", 32'(ev_valid), 32'd0);
        checkOutput("mid_rst_cnt_out", 32'(cnt_out), 32'd0);
        checkOutput("mid_rst_ev_data", ev_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(ev_valid), 32'd1);
        checkOutput("post_rst_entry", ev_data, 32'h8000_0000);
        hardware_fault_flag = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
